// File: rtl/aes_out_serializer_if.sv
// Handshake and status bundle between the AES result serializer and the
// logic around it: capture inputs, the 32-bit valid/ready word stream and
// the buffer status outputs.
interface aes_out_serializer_if #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic               AES_data_out_valid;
    logic [127:0]       AES_data_out;
    logic               ser_clr;
    logic               ser_ready;
    logic               ser_valid;
    logic [31:0]        ser_data;
    logic               ser_last;
    logic               ser_overflow;
    logic [CNT_W-1:0]   ser_block_cnt;
    logic [LVL_W-1:0]   ser_level;

    // Side that produces results and consumes the word stream.
    modport master (
        output AES_data_out_valid,
        output AES_data_out,
        output ser_clr,
        output ser_ready,
        input  ser_valid,
        input  ser_data,
        input  ser_last,
        input  ser_overflow,
        input  ser_block_cnt,
        input  ser_level
    );

    // The serializer itself.
    modport slave (
        input  AES_data_out_valid,
        input  AES_data_out,
        input  ser_clr,
        input  ser_ready,
        output ser_valid,
        output ser_data,
        output ser_last,
        output ser_overflow,
        output ser_block_cnt,
        output ser_level
    );
endinterface

// File: rtl/aes_out_serializer.sv
// AES result serializer: captures a 128-bit result on the rising edge of the
// core's valid, buffers up to DEPTH blocks and streams each one out as four
// 32-bit words, most-significant word first.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  ST_EMPTY  | no block held, ser_valid low
//  ST_STREAM | at least one block held, word word_idx_q of buf[rd_ptr]
//            | presented on ser_data
module aes_out_serializer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic               AES_clk,
    input  logic               AES_rst_n,
    aes_out_serializer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               valid_dly_q;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]         word_idx_q, word_idx_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       buf_q [DEPTH];

    logic               capture;
    logic               xfer;
    logic               pop;
    logic               full_after_pop;
    logic               accept;
    logic               drop;
    logic               ser_valid_c;
    logic               ser_last_c;
    logic [31:0]        ser_data_c;
    logic [127:0]       cur_blk;

    // Fullness is judged after a same-cycle pop so that a capture landing on
    // the final word handshake of a full buffer is still accepted.
    assign capture        = bus.AES_data_out_valid & ~valid_dly_q;
    assign xfer           = (state_q == ST_STREAM) & bus.ser_ready;
    assign pop            = xfer & (word_idx_q == 2'd3);
    assign full_after_pop = (level_q == LVL_W'(DEPTH)) & ~pop;
    assign accept         = capture & ~full_after_pop;
    assign drop           = capture & full_after_pop;
    assign cur_blk        = buf_q[rd_ptr_q];

    // State register.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) state_q <= ST_EMPTY;
        else            state_q <= state_d;
    end

    // Next state and stream outputs; everything here comes from flops only.
    always_comb begin
        state_d     = state_q;
        ser_valid_c = 1'b0;
        ser_last_c  = 1'b0;
        ser_data_c  = '0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                ser_valid_c = 1'b1;
                ser_last_c  = (word_idx_q == 2'd3);
                case (word_idx_q)
                    2'd0:    ser_data_c = cur_blk[127:96];
                    2'd1:    ser_data_c = cur_blk[95:64];
                    2'd2:    ser_data_c = cur_blk[63:32];
                    default: ser_data_c = cur_blk[31:0];
                endcase
                if (pop && !accept && level_q == LVL_W'(1)) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Pointer, occupancy and status next-state logic.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        word_idx_d = word_idx_q;
        level_d    = level_q;
        cnt_d      = bus.ser_clr ? '0 : cnt_q;
        overflow_d = (overflow_q & ~bus.ser_clr) | drop;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            cnt_d    = cnt_d + CNT_W'(1);
        end
        if (xfer) word_idx_d = word_idx_q + 2'd1;
        if (pop)  rd_ptr_d   = rd_ptr_q + PTR_W'(1);

        case ({accept, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Control and status registers; reset drops any partially sent block.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            valid_dly_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            word_idx_q  <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            valid_dly_q <= bus.AES_data_out_valid;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            word_idx_q  <= word_idx_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            cnt_q       <= cnt_d;
        end
    end

    // Block storage; contents are only meaningful while level_q covers them.
    always_ff @(posedge AES_clk) begin
        if (accept) buf_q[wr_ptr_q] <= bus.AES_data_out;
    end

    assign bus.ser_valid     = ser_valid_c;
    assign bus.ser_data      = ser_data_c;
    assign bus.ser_last      = ser_last_c;
    assign bus.ser_overflow  = overflow_q;
    assign bus.ser_block_cnt = cnt_q;
    assign bus.ser_level     = level_q;
endmodule

// File: tb/tb_aes_out_serializer.sv
module tb_aes_out_serializer;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    int   n_words;
    logic [32:0] exp_q [$];

    logic        stall_q;
    logic [31:0] stall_data;
    logic        stall_last;

    aes_out_serializer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    aes_out_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .AES_clk   (clk),
        .AES_rst_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_block(input logic [127:0] blk);
        for (int i = 0; i < 4; i++)
            exp_q.push_back({blk[127-32*i -: 32], (i == 3)});
    endtask

    // One-cycle valid pulse; expected words queued only when the block should be kept.
    task automatic pulse(input logic [127:0] blk, input bit keep);
        if (keep) push_block(blk);
        bus.AES_data_out       = blk;
        bus.AES_data_out_valid = 1'b1;
        tick();
        bus.AES_data_out_valid = 1'b0;
    endtask

    task automatic clr_pulse();
        bus.ser_clr = 1'b1;
        tick();
        bus.ser_clr = 1'b0;
    endtask

    // Output monitor: scoreboard pop on each handshake, stall stability, idle zeros.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("stall_valid", bus.ser_valid, 1'b1);
                chk("stall_data", bus.ser_data, stall_data);
                chk("stall_last", bus.ser_last, stall_last);
            end
            if (!bus.ser_valid) begin
                chk("idle_data", bus.ser_data, 32'h0);
                chk("idle_last", bus.ser_last, 1'b0);
            end
            if (bus.ser_valid && bus.ser_ready) begin
                n_words++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {bus.ser_data, bus.ser_last}, 33'h0);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("word_data", bus.ser_data, e[32:1]);
                    chk("word_last", bus.ser_last, e[0]);
                end
            end
            stall_q    = bus.ser_valid && !bus.ser_ready;
            stall_data = bus.ser_data;
            stall_last = bus.ser_last;
        end
    end

    initial begin
        logic [127:0] blk_a, blk_b, blk_c, blk_d;
        int w0;
        n_assert = 0;
        n_fail   = 0;
        n_words  = 0;
        stall_q  = 1'b0;

        // Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.AES_data_out       = {$urandom, $urandom, $urandom, $urandom};
            bus.AES_data_out_valid = 1'($urandom_range(0, 1));
            bus.ser_clr            = 1'($urandom_range(0, 1));
            bus.ser_ready          = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rst_valid", bus.ser_valid, 1'b0);
        chk("rst_data", bus.ser_data, 32'h0);
        chk("rst_last", bus.ser_last, 1'b0);
        chk("rst_overflow", bus.ser_overflow, 1'b0);
        chk("rst_cnt", bus.ser_block_cnt, 16'h0);
        chk("rst_level", bus.ser_level, 2'd0);
        bus.AES_data_out_valid = 1'b0;
        bus.ser_clr            = 1'b0;
        bus.ser_ready          = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_valid", bus.ser_valid, 1'b0);

        // Single block, first word visible the cycle after capture
        pulse(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1);
        chk("single_first_valid", bus.ser_valid, 1'b1);
        chk("single_first_data", bus.ser_data, 32'h00112233);
        chk("single_first_last", bus.ser_last, 1'b0);
        repeat (4) tick();
        chk("single_done_valid", bus.ser_valid, 1'b0);
        chk("single_cnt", bus.ser_block_cnt, 16'd1);
        chk("single_level", bus.ser_level, 2'd0);
        chk("single_drained", exp_q.size(), 0);

        // Held valid gives one capture
        clr_pulse();
        chk("clr_cnt", bus.ser_block_cnt, 16'd0);
        w0 = n_words;
        push_block(128'ha6f2daeb_140fa720_529e75d5_21cbc681);
        bus.AES_data_out       = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;
        bus.AES_data_out_valid = 1'b1;
        repeat (51) tick();
        bus.AES_data_out_valid = 1'b0;
        repeat (3) tick();
        chk("held_words", n_words - w0, 4);
        chk("held_cnt", bus.ser_block_cnt, 16'd1);
        chk("held_drained", exp_q.size(), 0);

        // Backpressure for 10 cycles
        bus.ser_ready = 1'b0;
        blk_a = 128'hdeadbeef_01234567_89abcdef_fedcba98;
        pulse(blk_a, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", bus.ser_valid, 1'b1);
            chk("bp_data", bus.ser_data, 32'hdeadbeef);
            tick();
        end
        bus.ser_ready = 1'b1;
        repeat (4) tick();
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_valid_after", bus.ser_valid, 1'b0);

        // Overflow with DEPTH=2 and a stalled sink
        clr_pulse();
        bus.ser_ready = 1'b0;
        blk_a = 128'h11111111_22222222_33333333_44444444;
        blk_b = 128'h55555555_66666666_77777777_88888888;
        blk_c = 128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc;
        pulse(blk_a, 1'b1);
        tick();
        pulse(blk_b, 1'b1);
        tick();
        chk("ovf_pre_flag", bus.ser_overflow, 1'b0);
        pulse(blk_c, 1'b0);
        chk("ovf_level", bus.ser_level, 2'd2);
        chk("ovf_cnt", bus.ser_block_cnt, 16'd2);
        chk("ovf_flag", bus.ser_overflow, 1'b1);
        clr_pulse();
        chk("ovf_clr_flag", bus.ser_overflow, 1'b0);
        chk("ovf_clr_cnt", bus.ser_block_cnt, 16'd0);
        chk("ovf_clr_level", bus.ser_level, 2'd2);
        w0 = n_words;
        bus.ser_ready = 1'b1;
        repeat (10) tick();
        chk("ovf_words", n_words - w0, 8);
        chk("ovf_drained", exp_q.size(), 0);
        chk("ovf_level_after", bus.ser_level, 2'd0);

        // Capture coinciding with the final handshake of a full buffer
        clr_pulse();
        bus.ser_ready = 1'b0;
        blk_a = 128'h0a0a0a0a_0b0b0b0b_0c0c0c0c_0d0d0d0d;
        blk_b = 128'h1a1a1a1a_1b1b1b1b_1c1c1c1c_1d1d1d1d;
        blk_c = 128'h2a2a2a2a_2b2b2b2b_2c2c2c2c_2d2d2d2d;
        pulse(blk_a, 1'b1);
        tick();
        pulse(blk_b, 1'b1);
        chk("sim_full_level", bus.ser_level, 2'd2);
        bus.ser_ready = 1'b1;
        repeat (3) tick();
        chk("sim_last_before", bus.ser_last, 1'b1);
        pulse(blk_c, 1'b1);
        chk("sim_overflow", bus.ser_overflow, 1'b0);
        chk("sim_level", bus.ser_level, 2'd2);
        chk("sim_cnt", bus.ser_block_cnt, 16'd3);
        chk("sim_next_block", bus.ser_data, 32'h1a1a1a1a);
        repeat (2) tick();

        // Reset mid-block
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus.ser_valid, 1'b0);
        chk("midrst_level", bus.ser_level, 2'd0);
        chk("midrst_data", bus.ser_data, 32'h0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_cnt", bus.ser_block_cnt, 16'd0);
        chk("midrst_valid_after", bus.ser_valid, 1'b0);

        // Recovery after reset
        blk_d = 128'hcafef00d_0badf00d_feedface_12345678;
        pulse(blk_d, 1'b1);
        chk("rec_first", bus.ser_data, 32'hcafef00d);
        repeat (4) tick();
        chk("rec_drained", exp_q.size(), 0);
        chk("rec_cnt", bus.ser_block_cnt, 16'd1);
        chk("rec_level", bus.ser_level, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
